// File: rtl/ice40_pipe_add_pkg.sv
// ============================================================================
// Module   : ice40_pipe_add_pkg
// Brief    : Shared helpers and stage-control type for the iCE40 pipelined adder
// Revision : 1.0
// ============================================================================
`default_nettype none

package ice40_pipe_add_pkg;

  // Number of pipeline segments for a given operand width.
  function automatic int nseg(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 1;
  endfunction

  // Configuration guard: width must split into whole segments.
  function automatic bit seg_cfg_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (seg_w <= width) && ((width % seg_w) == 0);
  endfunction

  // Control half of the per-stage register bundle; the datapath half is sized
  // by the top module's WIDTH.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

`default_nettype wire

// File: rtl/ice40_pipe_add_seg.sv
// ============================================================================
// Module   : ice40_pipe_add_seg
// Brief    : SEG_W-bit combinational ripple segment (LUT-XOR sum + SB_CARRY per bit)
// Revision : 1.0
// ============================================================================
`default_nettype none

module ice40_pipe_add_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  logic [SEG_W:0] w_c;

  assign w_c[0] = ci;

  generate
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
      assign s[i] = a[i] ^ b[i] ^ w_c[i];
      // SB_CARRY transfer function: CO = I0&I1 | CI&(I0|I1)
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] | b[i]));
    end
  endgenerate

  assign co = w_c[SEG_W];

endmodule

`default_nettype wire

// File: rtl/ice40_pipe_adder.sv
// ============================================================================
// Module   : ice40_pipe_adder
// Brief    : WIDTH-bit adder pipelined into WIDTH/SEG_W carry-registered segments.
//            Optional subtract mode via macro ICE40_PIPE_ADD_SUB_EN (adds SUB port).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ice40_pipe_adder
  import ice40_pipe_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
`ifdef ICE40_PIPE_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
  } stage_t;

  generate
    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_error
      $error("ice40_pipe_adder: WIDTH must be a positive multiple of SEG_W");
    end
  endgenerate

  stage_t           r_stage   [NSEG];
  logic [SEG_W-1:0] w_seg_a   [NSEG];
  logic [SEG_W-1:0] w_seg_b   [NSEG];
  logic [SEG_W-1:0] w_seg_s   [NSEG];
  logic             w_seg_ci  [NSEG];
  logic             w_seg_co  [NSEG];
  logic [WIDTH-1:0] w_sum_next[NSEG];
  logic [WIDTH-1:0] w_b_eff;
  logic             w_ci_eff;
  logic             w_advance;

  // Subtraction folds into the adder: A + ~B + ~CI, carry-out = no-borrow.
`ifdef ICE40_PIPE_ADD_SUB_EN
  assign w_b_eff  = SUB ? ~B : B;
  assign w_ci_eff = SUB ^ CI;
`else
  assign w_b_eff  = B;
  assign w_ci_eff = CI;
`endif

  assign w_advance = !r_stage[NSEG-1].ctl.valid || OUT_READY;
  assign IN_READY  = w_advance;

  generate
    for (genvar s = 0; s < NSEG; s++) begin : g_seg
      if (s == 0) begin : g_head
        assign w_seg_a[s]  = A[s*SEG_W +: SEG_W];
        assign w_seg_b[s]  = w_b_eff[s*SEG_W +: SEG_W];
        assign w_seg_ci[s] = w_ci_eff;
      end else begin : g_body
        assign w_seg_a[s]  = r_stage[s-1].opa[s*SEG_W +: SEG_W];
        assign w_seg_b[s]  = r_stage[s-1].opb[s*SEG_W +: SEG_W];
        assign w_seg_ci[s] = r_stage[s-1].ctl.carry;
      end

      ice40_pipe_add_seg #(
        .SEG_W (SEG_W)
      ) u_seg (
        .a  (w_seg_a[s]),
        .b  (w_seg_b[s]),
        .ci (w_seg_ci[s]),
        .s  (w_seg_s[s]),
        .co (w_seg_co[s])
      );
    end
  endgenerate

  // Finished low segments ride along with the transfer; stage s drops its slice in.
  always_comb begin
    w_sum_next[0]             = '0;
    w_sum_next[0][0 +: SEG_W] = w_seg_s[0];
    for (int s = 1; s < NSEG; s++) begin
      w_sum_next[s]                 = r_stage[s-1].sum;
      w_sum_next[s][s*SEG_W +: SEG_W] = w_seg_s[s];
    end
  end

  // Data registers load only behind a valid bit so idle-time X never enters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < NSEG; s++) begin
        r_stage[s] <= '0;
      end
    end else if (w_advance) begin
      r_stage[0].ctl.valid <= IN_VALID;
      if (IN_VALID) begin
        r_stage[0].ctl.carry <= w_seg_co[0];
        r_stage[0].opa       <= A;
        r_stage[0].opb       <= w_b_eff;
        r_stage[0].sum       <= w_sum_next[0];
      end
      for (int s = 1; s < NSEG; s++) begin
        r_stage[s].ctl.valid <= r_stage[s-1].ctl.valid;
        if (r_stage[s-1].ctl.valid) begin
          r_stage[s].ctl.carry <= w_seg_co[s];
          r_stage[s].opa       <= r_stage[s-1].opa;
          r_stage[s].opb       <= r_stage[s-1].opb;
          r_stage[s].sum       <= w_sum_next[s];
        end
      end
    end
  end

  assign OUT_VALID = r_stage[NSEG-1].ctl.valid;
  assign SUM       = r_stage[NSEG-1].sum;
  assign CO        = r_stage[NSEG-1].ctl.carry;

endmodule

`default_nettype wire

// File: tb/tb_ice40_pipe_adder.sv
// ============================================================================
// Module   : tb_ice40_pipe_adder
// Brief    : Scoreboard bench for ice40_pipe_adder (WIDTH=16, SEG_W=4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ice40_pipe_adder;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         CO;

  logic [W:0]   sb_q[$];
  logic [W:0]   exp_v;
  int           n_checks = 0;
  int           n_pass   = 0;

  ice40_pipe_adder #(
    .WIDTH (W),
    .SEG_W (4)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CI        (CI),
`ifdef ICE40_PIPE_ADD_SUB_EN
    .SUB       (SUB),
`endif
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .CO        (CO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~ci};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic drive_idle();
    IN_VALID = 1'b0;
    A        = 'x;
    B        = 'x;
    CI       = 1'bx;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sub);
    IN_VALID = 1'b1;
    A        = a;
    B        = b;
    CI       = ci;
    SUB      = sub;
  endtask

  task automatic test_reset();
    RESET_N   = 1'b0;
    OUT_READY = 1'b0;
    SUB       = 1'b0;
    drive_idle();
    repeat (3) @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); else n_pass++;
    n_checks++; if (SUM !== 16'h0) $display("FAIL reset_sum: got %h want 0000", SUM); else n_pass++;
    n_checks++; if (CO !== 1'b0) $display("FAIL reset_co: got %b want 0", CO); else n_pass++;
    n_checks++; if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", IN_READY); else n_pass++;
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_carry_chain();
    OUT_READY = 1'b1;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    sb_q.push_back(17'h10000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      drive_idle();
      n_checks++;
      if (OUT_VALID !== (c == 4)) $display("FAIL carry_latency c=%0d: out_valid got %b want %b", c, OUT_VALID, (c == 4));
      else n_pass++;
      if (OUT_VALID === 1'b1 && sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL carry_result: got %h want %h", {CO, SUM}, exp_v); else n_pass++;
      end
    end
    n_checks++; if (sb_q.size() != 0) $display("FAIL carry_drain: got %0d pending want 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W:0]   ve [3];
    va = '{16'h1234, 16'h8000, 16'h00FF};
    vb = '{16'h1111, 16'h8000, 16'h0000};
    vc = '{1'b0, 1'b0, 1'b1};
    ve = '{17'h02345, 17'h10000, 17'h00100};
    OUT_READY = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge CLK);
      n_checks++;
      if (OUT_VALID !== (c >= 4 && c <= 6)) $display("FAIL b2b_valid c=%0d: got %b want %b", c, OUT_VALID, (c >= 4 && c <= 6));
      else n_pass++;
      if (OUT_VALID === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++; $display("FAIL b2b_extra: got %h want no output", {CO, SUM});
        end else begin
          exp_v = sb_q.pop_front();
          n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL b2b_result: got %h want %h", {CO, SUM}, exp_v); else n_pass++;
        end
      end
      if (c < 3) begin
        drive_op(va[c], vb[c], vc[c], 1'b0);
        sb_q.push_back(ve[c]);
      end else begin
        drive_idle();
      end
    end
    n_checks++; if (sb_q.size() != 0) $display("FAIL b2b_drain: got %0d pending want 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n_sent  = 0;
    int n_stall = 0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge CLK);
      OUT_READY = !(c >= 4 && c <= 8);
      if (n_sent < 6) drive_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else drive_idle();
      #1;
      if (OUT_VALID === 1'b1 && !OUT_READY) begin
        n_stall++;
        n_checks++; if (IN_READY !== 1'b0) $display("FAIL bp_in_ready c=%0d: got %b want 0", c, IN_READY); else n_pass++;
        if (sb_q.size() > 0) begin
          n_checks++; if ({CO, SUM} !== sb_q[0]) $display("FAIL bp_hold c=%0d: got %h want %h", c, {CO, SUM}, sb_q[0]); else n_pass++;
        end
      end
      if (OUT_VALID === 1'b1 && OUT_READY) begin
        if (sb_q.size() == 0) begin
          n_checks++; $display("FAIL bp_extra: got %h want no output", {CO, SUM});
        end else begin
          exp_v = sb_q.pop_front();
          n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL bp_result: got %h want %h", {CO, SUM}, exp_v); else n_pass++;
        end
      end
      if (IN_VALID && IN_READY === 1'b1) begin
        sb_q.push_back(model(A, B, CI, 1'b0));
        n_sent++;
      end
    end
    n_checks++; if (n_stall != 5) $display("FAIL bp_stall_cycles: got %0d want 5", n_stall); else n_pass++;
    n_checks++; if (n_sent != 6) $display("FAIL bp_sent: got %0d want 6", n_sent); else n_pass++;
    n_checks++; if (sb_q.size() != 0) $display("FAIL bp_drain: got %0d pending want 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    OUT_READY = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge CLK);
      if (c < 3) drive_op(16'h1357 + 16'(c), 16'h2468, 1'b0, 1'b0);
      else drive_idle();
    end
    n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", OUT_VALID); else n_pass++;
    #2 RESET_N = 1'b0;
    #1;
    n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", OUT_VALID); else n_pass++;
    n_checks++; if (SUM !== 16'h0) $display("FAIL rst_async_sum: got %h want 0000", SUM); else n_pass++;
    n_checks++; if (CO !== 1'b0) $display("FAIL rst_async_co: got %b want 0", CO); else n_pass++;
    @(negedge CLK);
    RESET_N   = 1'b1;
    OUT_READY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) stale++;
    end
    n_checks++; if (stale != 0) $display("FAIL rst_stale: got %0d stale cycles want 0", stale); else n_pass++;
    drive_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    sb_q.push_back(17'h01001);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      drive_idle();
      n_checks++;
      if (OUT_VALID !== (c == 4)) $display("FAIL rst_latency c=%0d: got %b want %b", c, OUT_VALID, (c == 4));
      else n_pass++;
      if (OUT_VALID === 1'b1 && sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL rst_result: got %h want %h", {CO, SUM}, exp_v); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int n_acc = 0;
    int n_rcv = 0;
    int cyc   = 0;
    while (n_rcv < 10000 && cyc < 60000) begin
      @(negedge CLK);
      OUT_READY = ($urandom_range(0, 3) != 0);
      if (n_acc < 10000 && $urandom_range(0, 3) != 0) begin
`ifdef ICE40_PIPE_ADD_SUB_EN
        drive_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
        drive_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
`endif
      end else begin
        drive_idle();
      end
      #1;
      n_checks++;
      if (IN_READY !== (!OUT_VALID || OUT_READY)) $display("FAIL rnd_in_ready cyc=%0d: got %b want %b", cyc, IN_READY, (!OUT_VALID || OUT_READY));
      else n_pass++;
      if (OUT_VALID === 1'b1 && OUT_READY) begin
        if (sb_q.size() == 0) begin
          n_checks++; $display("FAIL rnd_extra cyc=%0d: got %h want no output", cyc, {CO, SUM});
        end else begin
          exp_v = sb_q.pop_front();
          n_rcv++;
          n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL rnd_result #%0d: got %h want %h", n_rcv, {CO, SUM}, exp_v); else n_pass++;
        end
      end
      if (IN_VALID && IN_READY === 1'b1) begin
        sb_q.push_back(model(A, B, CI, SUB));
        n_acc++;
      end
      cyc++;
    end
    n_checks++; if (n_rcv != 10000) $display("FAIL rnd_count: got %0d results want 10000", n_rcv); else n_pass++;
    drive_idle();
    SUB = 1'b0;
  endtask

`ifdef ICE40_PIPE_ADD_SUB_EN
  task automatic test_sub();
    OUT_READY = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge CLK);
      if (OUT_VALID === 1'b1 && sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        n_checks++; if ({CO, SUM} !== exp_v) $display("FAIL sub_result: got %h want %h", {CO, SUM}, exp_v); else n_pass++;
      end
      if (c == 0) begin
        drive_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        sb_q.push_back(17'h0FFFE);
      end else if (c == 1) begin
        drive_op(16'h0007, 16'h0005, 1'b1, 1'b1);
        sb_q.push_back(17'h10001);
      end else begin
        drive_idle();
      end
    end
    n_checks++; if (sb_q.size() != 0) $display("FAIL sub_drain: got %0d pending want 0", sb_q.size()); else n_pass++;
    SUB = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef ICE40_PIPE_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ice40_pipe_adder.md
Name: ice40_pipe_adder

Overview:
- Pipelined WIDTH-bit adder built from SEG_W-bit ripple segments. Each segment maps to one LUT-XOR plus SB_CARRY chain.
- Carry between segments is registered, so each segment occupies one pipeline stage. This keeps every carry chain short enough for high Fmax.
- Sits directly downstream of the carry-chain primitive layer (SB_CARRY / carry-wrapper LUTs) and is the first sequential consumer of their CO/O outputs.
- Used as the datapath adder for counters/accumulators in the iCE40 flow tests.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of SEG_W (elaboration error otherwise).
- SEG_W, 4, bits per pipeline segment; 1..WIDTH.

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  input operands valid
- IN_READY  out  1  block can accept operands this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CI  in  1  carry-in (borrow-in when SUB=1, see optional feature)
- OUT_VALID  out  1  SUM/CO valid
- OUT_READY  in  1  downstream accepts result
- SUM  out  WIDTH  A+B+CI modulo 2^WIDTH
- CO  out  1  carry-out of bit WIDTH-1

Behaviour:
- Reset: all internal state clears asynchronously on RESET_N=0; release is synchronous to CLK.
  - Cleared state: stage valids, skew/deskew registers, OUT_VALID=0, SUM=0, CO=0.
  - Any in-flight transfers are discarded; no partial result ever emerges.
- NSEG = WIDTH/SEG_W stages, indexed s=0..NSEG-1.
- Stage s computes SUM[s*SEG_W +: SEG_W] and a segment carry.
  - Carry-in: CI (stage 0) or the registered carry from stage s-1.
- Skew: operand bits for segment s are delayed s cycles. Deskew: finished sum segments travel forward with the transfer, so all segments of one transfer align at the output.
- Per-stage valid bit. The last stage's registers drive SUM, CO and OUT_VALID directly.
- Global advance:
  - advance = !OUT_VALID || OUT_READY.
  - IN_READY = advance (combinational from OUT_VALID/OUT_READY; no combinational path from IN_VALID).
  - Transfer accepted when IN_VALID && IN_READY.
- When advance=1, every stage shifts forward one position, with or without a valid bubble. When advance=0, all stages hold, and SUM/CO stay stable while OUT_VALID=1.
- Latency: NSEG cycles from the accept edge to OUT_VALID=1 (no stalls). Throughput: 1 result/cycle.
- Bubbles propagate as invalid stages. Output order equals input order.
- Arithmetic is unsigned modulo 2^WIDTH, and CO is the true carry of the full-width sum.
  - Example: A=0xFFFF, B=0x0000, CI=1 gives SUM=0x0000, CO=1.
- A, B, CI are sampled only on accept. Their values at other times are don't-care, and X on them must not propagate into valid state.
- Simultaneous accept and output handshake in the same cycle is legal and sustains full throughput.

Optional Feature:
- Macro: ICE40_PIPE_ADD_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit, sampled with operands on accept).
  - SUB=1: B is inverted per bit at stage entry, and the effective carry-in = ~CI. Result is A-B-CI, where CI is borrow-in.
  - CO=1 means no borrow occurred.
  - SUB=0: identical to the non-macro behaviour.
- Undefined: no SUB port, add-only. Area and timing are the same as the plain adder.

Decomposition:
- Package ice40_pipe_add_pkg:
  - function nseg(width, seg_w);
  - localparam-style check helper for WIDTH % SEG_W == 0;
  - typedef of the per-stage register bundle {valid, carry, operand-skew, sum-deskew}.
- Sub-module ice40_pipe_add_seg: one SEG_W-bit combinational segment. Inputs a, b, ci; outputs s, co. Implemented as XOR sum plus an SB_CARRY chain per bit.
- Top module: instantiates NSEG segments, the pipeline registers and the handshake logic.

Test Plan:
- WIDTH=16, SEG_W=4, OUT_READY=1. Accept A=0xFFFF, B=0x0001, CI=0 -> exactly 4 cycles later OUT_VALID=1, SUM=0x0000, CO=1 (carry crosses all stage registers).
- Back-to-back accepts of (0x1234+0x1111, CI=0), (0x8000+0x8000, CI=0), (0x00FF+0x0000, CI=1) -> on consecutive cycles: 0x2345/CO=0, 0x0000/CO=1, 0x0100/CO=0.
- Backpressure: result pending and OUT_READY=0 for 5 cycles -> IN_READY=0, SUM/CO/OUT_VALID held stable. On OUT_READY=1, results resume in order with none lost or duplicated.
- Reset mid-operation: assert RESET_N=0 with 3 transfers in flight -> OUT_VALID=0, SUM=0, CO=0 immediately (asynchronous). After release, no stale result appears; a new transfer has 4-cycle latency.
- Random stimulus with random IN_VALID/OUT_READY, 10k transfers -> scoreboard matches {CO,SUM} = A+B+CI exactly, in order.
- ICE40_PIPE_ADD_SUB_EN defined: A=0x0005, B=0x0007, SUB=1, CI=0 -> SUM=0xFFFE, CO=0. A=0x0007, B=0x0005, SUB=1, CI=1 -> SUM=0x0001, CO=1.
